// File: rtl/crawl_sound_player_if.sv
// Avalon-MM read port between the sound player and its sample ROM.
// The player is the master; the ROM answers with a fixed one-cycle read latency.
interface crawl_sound_player_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] rom_address;
  logic              rom_chipselect;
  logic              rom_clken;
  logic              rom_write;
  logic [1:0]        rom_byteenable;
  logic [15:0]       rom_readdata;

  modport master (
    output rom_address,
    output rom_chipselect,
    output rom_clken,
    output rom_write,
    output rom_byteenable,
    input  rom_readdata
  );

  modport slave (
    input  rom_address,
    input  rom_chipselect,
    input  rom_clken,
    input  rom_write,
    input  rom_byteenable,
    output rom_readdata
  );
endinterface

// File: rtl/crawl_sound_player.sv
// Streams 16-bit samples from a ROM to an audio codec, one per sample tick.
// Prefetches one word ahead and counts ticks that arrive before it is ready.
module crawl_sound_player #(
  parameter int NUM_WORDS = 9000,
  parameter int ADDR_W    = 14
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        loop,
  input  logic                        sample_tick,
  crawl_sound_player_if.master        rom,
  output logic [15:0]                 sample_data,
  output logic                        sample_valid,
  output logic                        busy,
  output logic                        done,
  output logic [7:0]                  underrun_count
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CAPTURE,
    READY
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       buf_q, buf_d;
  logic [15:0]       data_q, data_d;
  logic              loop_q, loop_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [7:0]        und_q, und_d;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      loop_q  <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      und_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      loop_q  <= loop_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      und_q   <= und_d;
    end
  end

  // Next-state logic: fetch, capture, wait for tick; stop wins over all
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    data_d  = data_q;
    loop_d  = loop_q;
    last_d  = last_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    und_d   = und_q;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          addr_d  = '0;
          loop_d  = loop;
          state_d = REQ;
        end
      end
      REQ: begin
        state_d = CAPTURE;
        if (sample_tick && und_q != 8'hFF)
          und_d = und_q + 8'd1;
      end
      CAPTURE: begin
        buf_d   = rom.rom_readdata;
        last_d  = (addr_q == LAST_ADDR);
        addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        state_d = READY;
        if (sample_tick && und_q != 8'hFF)
          und_d = und_q + 8'd1;
      end
      READY: begin
        if (sample_tick) begin
          data_d  = buf_q;
          valid_d = 1'b1;
          if (last_q && !loop_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      addr_d  = addr_q;
      buf_d   = buf_q;
      last_d  = last_q;
      data_d  = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      und_d   = und_q;
    end
  end

  assign rom.rom_address    = (state_q == REQ) ? addr_q : '0;
  assign rom.rom_chipselect = (state_q == REQ);
  assign rom.rom_clken      = (state_q == REQ);
  assign rom.rom_write      = 1'b0;
  assign rom.rom_byteenable = 2'b11;

  assign sample_data    = data_q;
  assign sample_valid   = valid_q;
  assign done           = done_q;
  assign busy           = (state_q != IDLE);
  assign underrun_count = und_q;

endmodule
